sha_digest_collector: RTL and testbench
=======================================

Name: sha_digest_collector

Overview:
- Downstream consumer of the SHA3 core's output AXI-Stream (TDATA_o/TVALID_o/TLAST_o/TUSER_o).
- Collects the DATA_WIDTH-bit digest beats of one packet into a flat, most-significant-word-first digest register and checks the beat count against the SHA3 variant carried in TUSER.
- Holds the digest for the host until it is acknowledged, back-pressuring the stream via TREADY meanwhile.

Parameters:
- DATA_WIDTH, 16, width of one stream beat in bits.
- MAX_WORDS, 32, digest buffer depth in beats (512 bits at DATA_WIDTH=16).

Ports:
- ACLK  input  1  system clock, rising edge.
- ARESETn  input  1  asynchronous active-low reset.
- S_TDATA  input  DATA_WIDTH  digest beat.
- S_TVALID  input  1  beat valid.
- S_TLAST  input  1  final beat of the digest packet.
- S_TUSER  input  4  bits [1:0] are the SHA3 variant; bits [3:2] are ignored.
- S_TREADY  output  1  collector can accept a beat.
- digest_ack  input  1  host has consumed the digest; single-cycle pulse.
- digest  output  MAX_WORDS*DATA_WIDTH  assembled digest.
- digest_valid  output  1  digest and status are stable.
- digest_words  output  6  beats stored for the current/last packet.
- length_err  output  1  the beat count did not match the variant.
- busy  output  1  a packet is in progress (COLLECT or DRAIN).

Behaviour:
- Handshake: a beat is accepted when S_TVALID && S_TREADY on a rising ACLK edge. S_TREADY is combinational from state: 1 in IDLE/COLLECT/DRAIN, 0 in DONE.
- Expected beat count N from TUSER[1:0]:
  - 0 → 14 (SHA3-224)
  - 1 → 16 (SHA3-256)
  - 2 → 24 (SHA3-384)
  - 3 → 32 (SHA3-512)
- The variant is latched from the first accepted beat only. TUSER changes mid-packet are ignored.
- Storage: beat k (0-based) is written to digest[(MAX_WORDS-1-k)*DATA_WIDTH +: DATA_WIDTH], i.e. the first beat is most significant. Unwritten positions stay 0.
- State machine: IDLE, COLLECT, DRAIN, DONE.
  - IDLE, on accepted beat:
    - Clear digest, then write beat 0 and latch the variant.
    - digest_words=1, length_err=0.
    - If S_TLAST: go to DONE with length_err=(N!=1) (always 1). Otherwise go to COLLECT.
  - COLLECT, on accepted beat:
    - Write at index digest_words, then increment digest_words.
    - If S_TLAST: go to DONE with length_err=(digest_words_new!=N).
    - Else if digest_words_new==N: go to DRAIN with length_err=1 (overrun; missing TLAST).
  - DRAIN: accepted beats are discarded; digest and digest_words are frozen. An accepted beat with S_TLAST goes to DONE.
  - DONE: digest_valid=1. On digest_ack go to IDLE and drop digest_valid on the same edge. digest, digest_words and length_err keep their values until the next packet's first beat.
- Latency: digest_valid rises on the edge that accepts the TLAST beat, so it is visible the next cycle. The earliest new beat is accepted the cycle after the ack.
- busy = (state==COLLECT || state==DRAIN).
- digest_ack outside DONE has no effect.
- No beat can arrive in DONE, since S_TREADY=0 there. An ack in DONE coinciding with S_TVALID does not accept the beat that cycle.
- Index never exceeds MAX_WORDS-1: N≤MAX_WORDS and DRAIN stops writes, so no wrap-around.
- Reset, including mid-packet: state=IDLE, digest=0, digest_words=0, length_err=0, digest_valid=0, busy=0, S_TREADY=1. Any partial packet is discarded.
- digest_words arithmetic: 6-bit unsigned, maximum 32.

Test Plan:
- SHA3-256 nominal: 16 beats 0x0001..0x0010, TUSER=1, TLAST on beat 16 → digest_valid=1 next cycle; digest[511:496]=0x0001, digest[271:256]=0x0010, digest[255:0]=0; digest_words=16; length_err=0; S_TREADY=0 until digest_ack.
- SHA3-512 with TVALID gaps and TUSER toggled to 0 mid-packet: 32 beats, TLAST on 32 → digest_words=32, length_err=0, all 512 bits filled. Variant stays 512.
- Early TLAST: TUSER=2 (384), TLAST on beat 10 → DONE, digest_words=10, length_err=1, digest beats 10..31 = 0.
- Overrun: TUSER=0 (224), 20 beats with TLAST on beat 20 → busy through DRAIN; digest_words=14, length_err=1; beats 15–20 absent from digest; digest_valid after beat 20.
- Back-pressure and ack: a second packet is presented while in DONE → no beat accepted (S_TREADY=0). digest_ack pulse → IDLE next cycle, first beat accepted the following cycle, previous digest cleared then.
- Reset mid-packet: ARESETn low after 5 beats of SHA3-256 → outputs immediately at reset values. A fresh 16-beat packet completes with length_err=0.

Source files
------------

// File: rtl/sha_digest_collector.sv
// Collects the digest beats of one SHA3 output packet into a flat register.
// The first beat lands in the most significant word. The beat count is
// checked against the variant carried in TUSER[1:0]. The result is held,
// with TREADY low, until the host acknowledges it.
module sha_digest_collector #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_WORDS  = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  input  logic [DATA_WIDTH-1:0]           S_TDATA,
  input  logic                            S_TVALID,
  input  logic                            S_TLAST,
  input  logic [3:0]                      S_TUSER,
  output logic                            S_TREADY,
  input  logic                            digest_ack,
  output logic [MAX_WORDS*DATA_WIDTH-1:0] digest,
  output logic                            digest_valid,
  output logic [5:0]                      digest_words,
  output logic                            length_err,
  output logic                            busy
);

  typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

  state_e                          state_q, state_d;
  logic [MAX_WORDS*DATA_WIDTH-1:0] digest_q, digest_d;
  logic [5:0]                      words_q, words_d;
  logic                            len_err_q, len_err_d;
  logic [1:0]                      variant_q, variant_d;

  logic       accept;
  logic       clr;
  logic       wr_en;
  logic [5:0] wr_idx;
  logic [5:0] words_inc;
  logic [5:0] exp_first;
  logic [5:0] exp_latched;
  logic       unused_tuser;

  // Upper TUSER bits carry nothing for this block.
  assign unused_tuser = ^S_TUSER[3:2];

  // Expected beat count for each SHA3 variant.
  function automatic logic [5:0] exp_words(input logic [1:0] v);
    unique case (v)
      2'd0:    exp_words = 6'd14;
      2'd1:    exp_words = 6'd16;
      2'd2:    exp_words = 6'd24;
      default: exp_words = 6'd32;
    endcase
  endfunction

  assign exp_first   = exp_words(S_TUSER[1:0]);
  assign exp_latched = exp_words(variant_q);
  assign accept      = S_TVALID && S_TREADY;
  assign words_inc   = words_q + 6'd1;

  // Next-state, storage control and status updates.
  always_comb begin
    state_d   = state_q;
    digest_d  = digest_q;
    words_d   = words_q;
    len_err_d = len_err_q;
    variant_d = variant_q;
    clr       = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = words_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          clr       = 1'b1;
          wr_en     = 1'b1;
          wr_idx    = 6'd0;
          variant_d = S_TUSER[1:0];
          words_d   = 6'd1;
          len_err_d = 1'b0;
          if (S_TLAST) begin
            state_d   = StDone;
            len_err_d = (exp_first != 6'd1);
          end else begin
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (accept) begin
          wr_en   = 1'b1;
          words_d = words_inc;
          if (S_TLAST) begin
            state_d   = StDone;
            len_err_d = (words_inc != exp_latched);
          end else if (words_inc == exp_latched) begin
            // Buffer full for this variant but no TLAST: swallow the rest.
            state_d   = StDrain;
            len_err_d = 1'b1;
          end
        end
      end
      StDrain: begin
        if (accept && S_TLAST) state_d = StDone;
      end
      StDone: begin
        if (digest_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (clr) digest_d = '0;
    if (wr_en) begin
      for (int unsigned i = 0; i < MAX_WORDS; i++) begin
        if (wr_idx == 6'(i)) digest_d[(MAX_WORDS-1-i)*DATA_WIDTH +: DATA_WIDTH] = S_TDATA;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= StIdle;
      digest_q  <= '0;
      words_q   <= '0;
      len_err_q <= 1'b0;
      variant_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      digest_q  <= digest_d;
      words_q   <= words_d;
      len_err_q <= len_err_d;
      variant_q <= variant_d;
    end
  end

  assign S_TREADY     = (state_q != StDone);
  assign digest_valid = (state_q == StDone);
  assign busy         = (state_q == StCollect) || (state_q == StDrain);
  assign digest       = digest_q;
  assign digest_words = words_q;
  assign length_err   = len_err_q;

endmodule

// File: tb/tb_sha_digest_collector.sv
// Directed bench for sha_digest_collector at the default 16-bit x 32 geometry.
module tb_sha_digest_collector;

  logic         ACLK;
  logic         ARESETn;
  logic [15:0]  S_TDATA;
  logic         S_TVALID;
  logic         S_TLAST;
  logic [3:0]   S_TUSER;
  logic         S_TREADY;
  logic         digest_ack;
  logic [511:0] digest;
  logic         digest_valid;
  logic [5:0]   digest_words;
  logic         length_err;
  logic         busy;

  int checks;
  int failures;
  logic [511:0] exp_dig;

  sha_digest_collector #(
    .DATA_WIDTH(16),
    .MAX_WORDS (32)
  ) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .S_TDATA     (S_TDATA),
    .S_TVALID    (S_TVALID),
    .S_TLAST     (S_TLAST),
    .S_TUSER     (S_TUSER),
    .S_TREADY    (S_TREADY),
    .digest_ack  (digest_ack),
    .digest      (digest),
    .digest_valid(digest_valid),
    .digest_words(digest_words),
    .length_err  (length_err),
    .busy        (busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one beat, let the next rising edge take it, sample 1 ns later.
  task automatic beat(input logic [15:0] d, input logic [3:0] u, input logic l);
    S_TDATA  = d;
    S_TUSER  = u;
    S_TLAST  = l;
    S_TVALID = 1'b1;
    @(posedge ACLK);
    #1;
    S_TVALID = 1'b0;
    S_TLAST  = 1'b0;
  endtask

  task automatic idle_cycle();
    S_TVALID = 1'b0;
    @(posedge ACLK);
    #1;
  endtask

  task automatic ack();
    digest_ack = 1'b1;
    @(posedge ACLK);
    #1;
    digest_ack = 1'b0;
  endtask

  task automatic put(input int k, input logic [15:0] d);
    exp_dig[(31-k)*16 +: 16] = d;
  endtask

  task automatic check_done(input string tag, input logic [5:0] words, input logic err);
    check({tag, "_valid"}, 512'(digest_valid), 512'(1'b1));
    check({tag, "_words"}, 512'(digest_words), 512'(words));
    check({tag, "_err"}, 512'(length_err), 512'(err));
    check({tag, "_digest"}, digest, exp_dig);
    check({tag, "_tready"}, 512'(S_TREADY), 512'(1'b0));
    check({tag, "_busy"}, 512'(busy), 512'(1'b0));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    ARESETn    = 1'b0;
    S_TDATA    = '0;
    S_TVALID   = 1'b0;
    S_TLAST    = 1'b0;
    S_TUSER    = '0;
    digest_ack = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_valid", 512'(digest_valid), 512'(1'b0));
    check("rst_busy", 512'(busy), 512'(1'b0));
    check("rst_tready", 512'(S_TREADY), 512'(1'b1));
    check("rst_words", 512'(digest_words), 512'(6'd0));
    check("rst_err", 512'(length_err), 512'(1'b0));
    check("rst_digest", digest, 512'(0));
    ARESETn = 1'b1;
    idle_cycle();

    // SHA3-256 nominal: 16 beats 1..16.
    exp_dig = '0;
    for (int i = 0; i < 16; i++) begin
      beat(16'(i + 1), 4'd1, i == 15);
      put(i, 16'(i + 1));
      if (i == 0) check("s256_busy", 512'(busy), 512'(1'b1));
    end
    check_done("s256", 6'd16, 1'b0);
    check("s256_top", 512'(digest[511:496]), 512'(16'h0001));
    check("s256_w15", 512'(digest[271:256]), 512'(16'h0010));
    check("s256_low", 512'(digest[255:0]), 512'(0));

    // Back-pressure: a beat offered in DONE must not be taken.
    S_TDATA  = 16'hAAAA;
    S_TUSER  = 4'd0;
    S_TVALID = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    check("bp_words", 512'(digest_words), 512'(6'd16));
    check("bp_digest", digest, exp_dig);
    // Ack with TVALID still high: the beat waits one more cycle.
    ack();
    check("ack_valid", 512'(digest_valid), 512'(1'b0));
    check("ack_tready", 512'(S_TREADY), 512'(1'b1));
    check("ack_digest_held", digest, exp_dig);
    check("ack_words_held", 512'(digest_words), 512'(6'd16));
    @(posedge ACLK);
    #1;
    S_TVALID = 1'b0;
    exp_dig = '0;
    put(0, 16'hAAAA);
    check("next_first_digest", digest, exp_dig);
    check("next_first_words", 512'(digest_words), 512'(6'd1));
    check("next_first_busy", 512'(busy), 512'(1'b1));

    // Continue as SHA3-224 overrun: 20 beats total, TLAST on 20.
    for (int i = 1; i < 20; i++) begin
      beat(16'hB000 + 16'(i), 4'd0, i == 19);
      if (i < 14) put(i, 16'hB000 + 16'(i));
      if (i == 13) begin
        check("ovr_drain_busy", 512'(busy), 512'(1'b1));
        check("ovr_drain_err", 512'(length_err), 512'(1'b1));
        check("ovr_drain_words", 512'(digest_words), 512'(6'd14));
      end
      if (i == 18) check("ovr_novalid", 512'(digest_valid), 512'(1'b0));
    end
    check_done("ovr", 6'd14, 1'b1);
    ack();

    // SHA3-512 with gaps, TUSER dropped to 0 after the first beat.
    exp_dig = '0;
    for (int i = 0; i < 32; i++) begin
      beat(16'h1000 + 16'(i), (i == 0) ? 4'd3 : 4'd0, i == 31);
      put(i, 16'h1000 + 16'(i));
      if (i % 5 == 4) idle_cycle();
    end
    check_done("s512", 6'd32, 1'b0);
    ack();

    // Early TLAST on SHA3-384 after 10 beats.
    exp_dig = '0;
    for (int i = 0; i < 10; i++) begin
      beat(16'h3000 + 16'(i), 4'd2, i == 9);
      put(i, 16'h3000 + 16'(i));
    end
    check_done("early", 6'd10, 1'b1);
    ack();

    // Single-beat packet straight from IDLE.
    exp_dig = '0;
    beat(16'h5A5A, 4'hD, 1'b1);
    put(0, 16'h5A5A);
    check_done("single", 6'd1, 1'b1);
    ack();

    // Reset mid-packet.
    for (int i = 0; i < 5; i++) beat(16'h7000 + 16'(i), 4'd1, 1'b0);
    ARESETn = 1'b0;
    #1;
    check("mrst_busy", 512'(busy), 512'(1'b0));
    check("mrst_words", 512'(digest_words), 512'(6'd0));
    check("mrst_digest", digest, 512'(0));
    check("mrst_tready", 512'(S_TREADY), 512'(1'b1));
    check("mrst_err", 512'(length_err), 512'(1'b0));
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    idle_cycle();
    exp_dig = '0;
    for (int i = 0; i < 16; i++) begin
      beat(16'h8000 + 16'(i), 4'd1, i == 15);
      put(i, 16'h8000 + 16'(i));
    end
    check_done("fresh", 6'd16, 1'b0);
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
